// File: rtl/pipelined_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined carry-chain adder.
// Imported by pipelined_adder and adder_chunk.
package pipelined_adder_pkg;

    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctrl_t;

    function automatic int unsigned chunk_w(input int unsigned width, input int unsigned stages);
        return (stages == 0) ? 0 : width / stages;
    endfunction

    function automatic bit split_ok(input int unsigned width, input int unsigned stages);
        return (stages != 0) && (width >= 1) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational C-bit ripple adder built from single-bit full-adder cells;
// one instance sits in each pipeline stage of pipelined_adder.
module adder_chunk
    import pipelined_adder_pkg::*;
#(
    parameter int unsigned C = 1
) (
    input  logic [C-1:0] a,
    input  logic [C-1:0] b,
    input  logic         cin,
    output logic [C-1:0] sum,
    output logic         cout
);

    always_comb begin
        logic carry;
        carry = cin;
        sum   = '0;
        for (int unsigned i = 0; i < C; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (b[i] & carry) | (carry & a[i]);
        end
        cout = carry;
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder, one C-bit chunk per stage, valid/ready on both sides.
// Optional subtract/overflow support is compiled in with `define ADDER_SUB_EN.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
`ifdef ADDER_SUB_EN
    input  logic             SUB,
`endif
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT
`ifdef ADDER_SUB_EN
    ,
    output logic             OVF
`endif
);

    localparam int unsigned C    = chunk_w(WIDTH, STAGES);
    localparam int unsigned LAST = STAGES - 1;

    if (!split_ok(WIDTH, STAGES)) begin : cfg_check_g
        $error("pipelined_adder: WIDTH (%0d) must be a non-zero multiple of STAGES (%0d)", WIDTH, STAGES);
    end

    logic adv;

    // The whole pipe moves in lockstep, bubbles included, so one shared enable suffices.
    assign IN_READY = ~OUT_VALID | OUT_READY;
    assign adv      = IN_READY;

    for (genvar k = 0; k < STAGES; k++) begin : stage_g
        localparam int unsigned REST = WIDTH - (k + 1) * C;

        logic [C-1:0]         a_chunk;
        logic [C-1:0]         b_raw;
        logic [C-1:0]         b_chunk;
        logic [C-1:0]         chunk_sum;
        logic                 c_in;
        logic                 c_out;
        logic                 v_in;
        logic                 sub_in;
        logic [(k+1)*C-1:0]   s_next;
        logic [(k+1)*C-1:0]   s_q;
        stage_ctrl_t          ctrl_q;
        logic                 stage_valid;
        logic                 stage_carry;

        assign stage_valid = ctrl_q.valid;
        assign stage_carry = ctrl_q.carry;
        assign b_chunk     = b_raw ^ {C{sub_in}};

        adder_chunk #(.C(C)) chunk_u (
            .a    (a_chunk),
            .b    (b_chunk),
            .cin  (c_in),
            .sum  (chunk_sum),
            .cout (c_out)
        );

        if (k == 0) begin : src_g
            assign a_chunk = A[C-1:0];
            assign b_raw   = B[C-1:0];
            assign v_in    = IN_VALID;
            assign s_next  = chunk_sum;
`ifdef ADDER_SUB_EN
            assign sub_in  = SUB;
            assign c_in    = SUB ? 1'b1 : CIN;
`else
            assign sub_in  = 1'b0;
            assign c_in    = CIN;
`endif
        end else begin : src_g
            assign a_chunk = stage_g[k-1].skew_g.a_q[C-1:0];
            assign b_raw   = stage_g[k-1].skew_g.b_q[C-1:0];
            assign v_in    = stage_g[k-1].stage_valid;
            assign c_in    = stage_g[k-1].stage_carry;
            assign s_next  = {chunk_sum, stage_g[k-1].s_q};
`ifdef ADDER_SUB_EN
            assign sub_in  = stage_g[k-1].skew_g.sub_q;
`else
            assign sub_in  = 1'b0;
`endif
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                ctrl_q <= '0;
                s_q    <= '0;
            end else if (adv) begin
                ctrl_q.valid <= v_in;
                ctrl_q.carry <= c_out;
                s_q          <= s_next;
            end
        end

        // Skew registers keep only the chunks not yet added, shrinking by C per stage.
        if (k < LAST) begin : skew_g
            logic [REST-1:0] a_up;
            logic [REST-1:0] b_up;
            logic [REST-1:0] a_q;
            logic [REST-1:0] b_q;
`ifdef ADDER_SUB_EN
            logic            sub_q;
`endif

            if (k == 0) begin : up_g
                assign a_up = A[WIDTH-1:C];
                assign b_up = B[WIDTH-1:C];
            end else begin : up_g
                assign a_up = stage_g[k-1].skew_g.a_q[REST+C-1:C];
                assign b_up = stage_g[k-1].skew_g.b_q[REST+C-1:C];
            end

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    a_q   <= '0;
                    b_q   <= '0;
`ifdef ADDER_SUB_EN
                    sub_q <= 1'b0;
`endif
                end else if (adv) begin
                    a_q   <= a_up;
                    b_q   <= b_up;
`ifdef ADDER_SUB_EN
                    sub_q <= sub_in;
`endif
                end
            end
        end

`ifdef ADDER_SUB_EN
        if (k == LAST) begin : ovf_g
            logic ovf_q;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= (a_chunk[C-1] == b_chunk[C-1]) && (chunk_sum[C-1] != a_chunk[C-1]);
                end
            end
        end
`endif
    end

    assign OUT_VALID = stage_g[LAST].stage_valid;
    assign COUT      = stage_g[LAST].stage_carry;
    assign SUM       = stage_g[LAST].s_q;
`ifdef ADDER_SUB_EN
    assign OVF       = stage_g[LAST].ovf_g.ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench: W=8/S=2 directed sequence, then exhaustive W=4 at S=1,2,4.
module tb_pipelined_adder;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } res8_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // W=8, S=2 instance
    logic       in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;
    res8_t      q8 [$];
    res8_t      e8;

    pipelined_adder #(.WIDTH(8), .STAGES(2)) dut8 (
        .CLK       (clk),
        .RST       (rst),
        .IN_VALID  (in_valid8),
        .IN_READY  (in_ready8),
        .A         (a8),
        .B         (b8),
        .CIN       (cin8),
`ifdef ADDER_SUB_EN
        .SUB       (sub8),
        .OVF       (ovf8),
`endif
        .OUT_VALID (out_valid8),
        .OUT_READY (out_ready8),
        .SUM       (sum8),
        .COUT      (cout8)
    );

`ifndef ADDER_SUB_EN
    assign ovf8 = 1'b0;
`endif

    function automatic res8_t model8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
        logic [7:0] bb;
        logic       c;
        logic [8:0] t;
        res8_t      r;
        bb     = sub ? ~b : b;
        c      = sub ? 1'b1 : cin;
        t      = {1'b0, a} + {1'b0, bb} + {8'b0, c};
        r.sum  = t[7:0];
        r.cout = t[8];
        r.ovf  = (a[7] == bb[7]) && (t[7] != a[7]);
        return r;
    endfunction

    function automatic logic rnd_sub();
`ifdef ADDER_SUB_EN
        return 1'($urandom);
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic sub, input logic ordy);
        in_valid8  = v;
        a8         = a;
        b8         = b;
        cin8       = cin;
        sub8       = sub;
        out_ready8 = ordy;
        @(negedge clk);
        if (in_valid8 && in_ready8) q8.push_back(model8(a, b, cin, sub));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid8 && out_ready8) begin
            check("d8_has_expected", 32'(q8.size() > 0), 32'(1));
            if (q8.size() > 0) begin
                e8 = q8.pop_front();
                check("d8_sum", 32'(sum8), 32'(e8.sum));
                check("d8_cout", 32'(cout8), 32'(e8.cout));
`ifdef ADDER_SUB_EN
                check("d8_ovf", 32'(ovf8), 32'(e8.ovf));
`endif
            end
        end
    end

    // W=4 instances share operands and only accept when all three are ready
    logic       drv4_valid, v4, cin4, out_ready4;
    logic [3:0] a4, b4;
    logic [4:0] q4 [3][$];

    for (genvar g = 0; g < 3; g++) begin : w4_g
        localparam int unsigned S = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        logic       rdy, ov, co, ovf_nc;
        logic [3:0] sm;
        logic [4:0] e;

        pipelined_adder #(.WIDTH(4), .STAGES(S)) dut4 (
            .CLK       (clk),
            .RST       (rst),
            .IN_VALID  (v4),
            .IN_READY  (rdy),
            .A         (a4),
            .B         (b4),
            .CIN       (cin4),
`ifdef ADDER_SUB_EN
            .SUB       (1'b0),
            .OVF       (ovf_nc),
`endif
            .OUT_VALID (ov),
            .OUT_READY (out_ready4),
            .SUM       (sm),
            .COUT      (co)
        );

`ifndef ADDER_SUB_EN
        assign ovf_nc = 1'b0;
`endif

        always @(negedge clk) begin
            if (!rst && ov && out_ready4) begin
                check($sformatf("w4s%0d_has_expected", S), 32'(q4[g].size() > 0), 32'(1));
                if (q4[g].size() > 0) begin
                    e = q4[g].pop_front();
                    check($sformatf("w4s%0d_result", S), 32'({co, sm}), 32'(e));
                end
            end
        end
    end

    assign v4 = drv4_valid & w4_g[0].rdy & w4_g[1].rdy & w4_g[2].rdy;

    task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic c);
        bit          done;
        int unsigned tries;
        logic [4:0]  r;
        done  = 1'b0;
        tries = 0;
        a4    = a;
        b4    = b;
        cin4  = c;
        while (!done && tries < 64) begin
            drv4_valid = ($urandom_range(0, 2) != 0);
            out_ready4 = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (v4) begin
                r = {1'b0, a} + {1'b0, b} + {4'b0, c};
                q4[0].push_back(r);
                q4[1].push_back(r);
                q4[2].push_back(r);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            tries++;
        end
        check("w4_accept_within_budget", 32'(done), 32'(1));
        drv4_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        rst        = 1'b1;
        in_valid8  = 1'b0;
        a8         = '0;
        b8         = '0;
        cin8       = 1'b0;
        sub8       = 1'b0;
        out_ready8 = 1'b0;
        drv4_valid = 1'b0;
        a4         = '0;
        b4         = '0;
        cin4       = 1'b0;
        out_ready4 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid8), 32'(0));
        check("rst_sum", 32'(sum8), 32'(0));
        check("rst_cout", 32'(cout8), 32'(0));
        check("rst_in_ready", 32'(in_ready8), 32'(1));
`ifdef ADDER_SUB_EN
        check("rst_ovf", 32'(ovf8), 32'(0));
`endif
        rst = 1'b0;

        // FF + 01: result visible after the second edge
        drive8(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
        check("lat_not_early", 32'(out_valid8), 32'(0));
        drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        check("lat_valid", 32'(out_valid8), 32'(1));
        check("ff01_sum", 32'(sum8), 32'(8'h00));
        check("ff01_cout", 32'(cout8), 32'(1));
        drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        check("single_no_repeat", 32'(out_valid8), 32'(0));

        for (int i = 0; i < 18; i++) begin
            if (i < 16) drive8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), rnd_sub(), 1'b1);
            else        drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
            check("stream_in_ready", 32'(in_ready8), 32'(1));
            check("stream_out_valid", 32'(out_valid8), 32'(i >= 1 && i <= 16));
        end

        drive8(1'b1, 8'h12, 8'h34, 1'b1, 1'b0, 1'b0);
        check("bp_fill_ready", 32'(in_ready8), 32'(1));
        drive8(1'b1, 8'hF0, 8'h0F, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive8(1'b1, 8'hAA, 8'h55, 1'b0, 1'b0, 1'b0);
            check("bp_in_ready", 32'(in_ready8), 32'(0));
            check("bp_out_valid", 32'(out_valid8), 32'(1));
            check("bp_sum_hold", 32'(sum8), 32'(8'h47));
            check("bp_cout_hold", 32'(cout8), 32'(0));
        end
        drive8(1'b1, 8'hAA, 8'h55, 1'b0, 1'b0, 1'b1);
        check("bp_release_sum", 32'(sum8), 32'(8'h00));
        check("bp_release_cout", 32'(cout8), 32'(1));
        repeat (3) drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        check("bp_no_loss", 32'(q8.size()), 32'(0));
        check("bp_drained", 32'(out_valid8), 32'(0));

        drive8(1'b1, 8'h01, 8'h02, 1'b0, 1'b0, 1'b1);
        drive8(1'b1, 8'h03, 8'h04, 1'b0, 1'b0, 1'b1);
        in_valid8 = 1'b0;
        check("pre_rst_valid", 32'(out_valid8), 32'(1));
        rst = 1'b1;
        #1;
        check("rst_async_valid", 32'(out_valid8), 32'(0));
        check("rst_async_sum", 32'(sum8), 32'(0));
        q8.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
            check("post_rst_silent", 32'(out_valid8), 32'(0));
        end

`ifdef ADDER_SUB_EN
        drive8(1'b1, 8'h05, 8'h07, 1'b1, 1'b1, 1'b1);
        drive8(1'b1, 8'h80, 8'h01, 1'b0, 1'b1, 1'b1);
        check("sub_5_7_sum", 32'(sum8), 32'(8'hFE));
        check("sub_5_7_cout", 32'(cout8), 32'(0));
        check("sub_5_7_ovf", 32'(ovf8), 32'(0));
        drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        check("sub_80_1_sum", 32'(sum8), 32'(8'h7F));
        check("sub_80_1_cout", 32'(cout8), 32'(1));
        check("sub_80_1_ovf", 32'(ovf8), 32'(1));
        drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
`endif

        for (int i = 0; i < 60; i++) begin
            drive8(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom), rnd_sub(),
                   ($urandom_range(0, 3) != 0));
        end
        repeat (6) drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        check("rand_drain", 32'(q8.size()), 32'(0));

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    drive4(4'(a), 4'(b), 1'(c));
                end
            end
        end
        drv4_valid = 1'b0;
        out_ready4 = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("w4s1_drain", 32'(q4[0].size()), 32'(0));
        check("w4s2_drain", 32'(q4[1].size()), 32'(0));
        check("w4s4_drain", 32'(q4[2].size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
